timingskew_calibrator: RTL and testbench



---
 rtl/timingskew_calibrator_pkg.sv | 33 +++
 rtl/timingskew_sync.sv | 41 ++++
 rtl/timingskew_calibrator.sv | 203 ++++++++++++++++++++
 tb/tb_timingskew_calibrator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timingskew_calibrator_pkg.sv
// Shared definitions for the skew-cell calibrator: FSM states, code width,
// power-on code and a small helper for the successive-approximation search.
package timingskew_cal_pkg;

    // Width of the trim code driven into the skew cell
    localparam int CODE_W = 5;

    // Code presented to the skew cell out of reset
    localparam logic [CODE_W-1:0] POR_CODE = 5'h00;

    // Index of the most significant code bit, where every search begins
    localparam logic [2:0] MSB_IDX = 3'd4;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETBIT  = 3'd1,
        SETTLE  = 3'd2,
        PULSE   = 3'd3,
        MEASURE = 3'd4,
        JUDGE   = 3'd5,
        DONE    = 3'd6
    } cal_state_t;

    // One-hot mask selecting the code bit currently under trial
    function automatic logic [CODE_W-1:0] bit_mask(input logic [2:0] idx);
        logic [CODE_W-1:0] one;
        one      = '0;
        one[0]   = 1'b1;
        bit_mask = one << idx;
    endfunction

endpackage

// File: rtl/timingskew_sync.sv
// Multi-flop synchronizer bringing the asynchronous skew cell output into the
// calibration clock domain. Stage 0 samples the raw input; the last stage is
// the only one the rest of the design may look at.
module timingskew_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous input directly
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= d;
                    end
                end
            end else begin : g_chain
                // Later stages give the first stage time to resolve metastability
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/timingskew_calibrator.sv
// SAR calibrator for the rise-edge programmable skew cell. For each code bit,
// MSB first, it tentatively sets the bit, lets the cell settle, launches a
// rising test edge and counts CELCLK cycles until the cell's delayed edge
// comes back. A bit is kept only if the measured count does not exceed the
// programmed target, so the final code is the largest delay within target.
module timingskew_calibrator
    import timingskew_cal_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             CELCLK,
    input  logic             CELRSTB,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             CELSUB,
    input  logic             start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic             skew_out,
    output logic             cal_in,
    output logic [4:0]       factory_timingskew,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] meas_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYC - 1);

    // Supply, ground and substrate pins are physical only
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ CELSUB;

    cal_state_t        state_reg,  state_next;
    logic [CODE_W-1:0] code_reg,   code_next;
    logic [2:0]        idx_reg,    idx_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [CNT_W-1:0]  settle_reg, settle_next;
    logic [CNT_W-1:0]  meas_reg,   meas_next;
    logic              cal_in_reg, cal_in_next;
    logic              done_reg,   done_next;
    logic              terr_reg,   terr_next;
    logic              armed_reg;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  settle_inc;
    logic [CODE_W-1:0] cur_mask;
    logic              ss_out;

    // Returned edge from the skew cell, brought into the CELCLK domain
    timingskew_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CELCLK),
        .rst_n (CELRSTB),
        .d     (skew_out),
        .q     (ss_out)
    );

    assign cur_mask = bit_mask(idx_reg);

    // Saturating increments so neither counter can wrap past TIMEOUT
    always_comb begin
        cnt_inc    = cnt_reg;
        settle_inc = settle_reg;
        if (cnt_reg != TIMEOUT_C) begin
            cnt_inc = cnt_reg + 1'b1;
        end
        if (settle_reg != TIMEOUT_C) begin
            settle_inc = settle_reg + 1'b1;
        end
    end

    // Sequencer next-state and datapath updates
    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        settle_next = settle_reg;
        meas_next   = meas_reg;
        cal_in_next = cal_in_reg;
        done_next   = done_reg;
        terr_next   = terr_reg;

        case (state_reg)
            IDLE: begin
                // armed_reg keeps a start coinciding with reset release out
                if (start && armed_reg) begin
                    code_next  = POR_CODE;
                    idx_next   = MSB_IDX;
                    done_next  = 1'b0;
                    terr_next  = 1'b0;
                    state_next = SETBIT;
                end
            end

            SETBIT: begin
                code_next   = code_reg | cur_mask;
                settle_next = '0;
                state_next  = SETTLE;
            end

            SETTLE: begin
                cal_in_next = 1'b0;
                settle_next = settle_inc;
                if (!ss_out && (settle_reg >= SETTLE_LAST)) begin
                    state_next = PULSE;
                end else if (ss_out && (settle_reg >= TIMEOUT_LAST)) begin
                    // Cell never released its output: count the trial as too slow
                    meas_next  = TIMEOUT_C;
                    terr_next  = 1'b1;
                    state_next = JUDGE;
                end
            end

            PULSE: begin
                cal_in_next = 1'b1;
                cnt_next    = '0;
                state_next  = MEASURE;
            end

            MEASURE: begin
                cnt_next = cnt_inc;
                if (ss_out) begin
                    meas_next  = cnt_inc;
                    state_next = JUDGE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    meas_next  = TIMEOUT_C;
                    terr_next  = 1'b1;
                    state_next = JUDGE;
                end
            end

            JUDGE: begin
                if (meas_reg > target_cnt) begin
                    code_next = code_reg & ~cur_mask;
                end
                cal_in_next = 1'b0;
                if (idx_reg == 3'd0) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg - 3'd1;
                    state_next = SETBIT;
                end
            end

            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            state_reg  <= IDLE;
            code_reg   <= POR_CODE;
            idx_reg    <= MSB_IDX;
            cnt_reg    <= '0;
            settle_reg <= '0;
            meas_reg   <= '0;
            cal_in_reg <= 1'b0;
            done_reg   <= 1'b0;
            terr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            settle_reg <= settle_next;
            meas_reg   <= meas_next;
            cal_in_reg <= cal_in_next;
            done_reg   <= done_next;
            terr_reg   <= terr_next;
        end
    end

    // Goes high on the first clock after reset release; gates start acceptance
    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
        end
    end

    assign cal_in             = cal_in_reg;
    assign factory_timingskew = code_reg;
    assign busy               = (state_reg != IDLE);
    assign done               = done_reg;
    assign timeout_err        = terr_reg;
    assign meas_cnt           = meas_reg;

endmodule

// File: tb/tb_timingskew_calibrator.sv
// Bench for timingskew_calibrator. A cell model returns the test edge so that
// the measured count equals code+5 (or never returns it when stuck low). An
// abstract SAR model predicts each trial's code, count, duration and the
// final result; a monitor compares the DUT against it every clock.
module tb_timingskew_calibrator;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       skew_out = 1'b0;
    logic [7:0] target_cnt = 8'd0;
    logic       cal_in, busy, done, timeout_err;
    logic [4:0] code;
    logic [7:0] meas_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timingskew_calibrator #(
        .CNT_W       (8),
        .SETTLE_CYC  (4),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CELCLK             (clk),
        .CELRSTB            (rst_n),
        .CELV               (1'b1),
        .CELG               (1'b0),
        .CELSUB             (1'b0),
        .start              (start),
        .target_cnt         (target_cnt),
        .skew_out           (skew_out),
        .cal_in             (cal_in),
        .factory_timingskew (code),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .meas_cnt           (meas_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Skew cell: raises skew_out code+3 negedges after cal_in rises, which
    // through the two-flop synchronizer yields a measured count of code+5
    bit stuck_low = 1'b0;
    int hi_run = 0;
    initial forever begin
        @(negedge clk);
        if (stuck_low || !cal_in) begin
            skew_out = 1'b0;
            hi_run   = 0;
        end else begin
            hi_run++;
            if (hi_run >= int'(code) + 3) skew_out = 1'b1;
        end
    end

    // Abstract SAR model of one calibration
    int exp_code [5];
    int exp_meas [5];
    int exp_after[5];
    int exp_final;
    int exp_busy;
    bit exp_to;

    function automatic void build_model(input int tgt, input bit stk);
        int c;
        int trial_code;
        int m;
        c        = 0;
        exp_busy = 1;
        exp_to   = stk;
        for (int t = 0; t < 5; t++) begin
            trial_code = c + (1 << (4 - t));
            m          = stk ? TIMEOUT : trial_code + 5;
            if (m <= tgt) c = trial_code;
            exp_code[t]  = trial_code;
            exp_meas[t]  = m;
            exp_after[t] = c;
            // SETBIT + 4 settle + PULSE + m measure cycles + JUDGE
            exp_busy += 7 + m;
        end
        exp_final = c;
    endfunction

    // Monitor: compares the DUT with the model on every clock
    bit   mon_en = 1'b0;
    int   trial = 0;
    int   hi_cyc = 0;
    int   busy_cyc = 0;
    int   cal_count = 0;
    logic pbusy = 1'b0, pcal = 1'b0, pdone = 1'b0;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (!busy) chk("cal_in_low_when_idle", {31'd0, cal_in}, 32'd0);
            if (busy && !pbusy) begin
                trial    = 0;
                busy_cyc = 0;
            end
            if (busy) busy_cyc++;
            if (cal_in && !pcal) begin
                if (trial < 5) chk("trial_code", {27'd0, code}, exp_code[trial]);
                else           chk("trial_count_overrun", trial, 4);
                hi_cyc = 1;
            end else if (cal_in) begin
                hi_cyc++;
            end
            if (!cal_in && pcal) begin
                if (trial < 5) begin
                    chk("trial_meas_cnt", {24'd0, meas_cnt}, exp_meas[trial]);
                    chk("trial_edge_cycles", hi_cyc, exp_meas[trial] + 1);
                    chk("trial_code_after_judge", {27'd0, code}, exp_after[trial]);
                end
                trial++;
            end
            if (done && !pdone) begin
                chk("cal_trials", trial, 5);
                chk("cal_busy_low_at_done", {31'd0, busy}, 32'd0);
                chk("cal_busy_cycles", busy_cyc, exp_busy);
                chk("cal_final_code", {27'd0, code}, exp_final);
                chk("cal_timeout_err", {31'd0, timeout_err}, {31'd0, exp_to});
                cal_count++;
            end
        end
        pbusy = busy;
        pcal  = cal_in;
        pdone = done;
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_cal(input string tag, input int tgt, input bit stk,
                           input int lit_code, input int lit_meas, input bit lit_to);
        build_model(tgt, stk);
        target_cnt = 8'(tgt);
        stuck_low  = stk;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
        chk({tag, "_code"}, {27'd0, code}, lit_code);
        chk({tag, "_meas_cnt"}, {24'd0, meas_cnt}, lit_meas);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, lit_to});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        $display("cal %s target=%0d stuck=%0d code=%0h meas=%0d terr=%0d",
                 tag, tgt, stk, code, meas_cnt, timeout_err);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : seq
        int n;
        int cal_before;

        // Reset values, with start held high across reset release
        #1 rst_n = 1'b0;
        target_cnt = 8'd20;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_code", {27'd0, code}, 32'h00);
        chk("reset_cal_in", {31'd0, cal_in}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("reset_meas_cnt", {24'd0, meas_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_reset_release_ignored", {31'd0, busy}, 32'd0);
        $display("reset checks done");
        mon_en = 1'b1;

        run_cal("t20",   20,  1'b0, 32'h0F, 20,  1'b0);
        run_cal("t255",  255, 1'b0, 32'h1F, 36,  1'b0);
        run_cal("t0",    0,   1'b0, 32'h00, 6,   1'b0);
        chk("t0_done_flag", {31'd0, done}, 32'd1);
        run_cal("stuck", 20,  1'b1, 32'h00, 255, 1'b1);
        stuck_low = 1'b0;

        // start pulses while busy are ignored
        build_model(20, 1'b0);
        target_cnt = 8'd20;
        cal_before = cal_count;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("busy_start");
        @(negedge clk);
        chk("busy_start_code", {27'd0, code}, 32'h0F);
        chk("busy_start_one_cal", cal_count - cal_before, 1);
        chk("busy_start_stays_idle", {31'd0, busy}, 32'd0);
        $display("cal busy_start code=%0h", code);

        // Reset during MEASURE of the third trial
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(trial == 2 && cal_in === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_trial3", {31'd0, cal_in}, 32'd1);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_code", {27'd0, code}, 32'h00);
        chk("abort_cal_in", {31'd0, cal_in}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_meas_cnt", {24'd0, meas_cnt}, 32'd0);
        $display("abort checks done");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        run_cal("after_abort", 20, 1'b0, 32'h0F, 20, 1'b0);

        // start held through DONE restarts immediately with done cleared
        cal_before = cal_count;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        wait_done("held1");
        @(negedge clk);
        chk("held_restart_done_cleared", {31'd0, done}, 32'd0);
        chk("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("held2");
        @(negedge clk);
        chk("held_code", {27'd0, code}, 32'h0F);
        chk("held_two_cals", cal_count - cal_before, 2);
        $display("cal held_start code=%0h", code);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
